fetch_pc_seq: RTL and testbench

//   Program-counter and instruction-fetch sequencer of the CPU core.
//   - Holds the PC and fetches each instruction word from instruction memory over a req/ready handshake.
//   - Registers the fetched word and exports its imm16 field to the 16->32 sign extender.
//   - Consumes the sign-extended immediate back as the branch offset when it computes the next PC.

---
 rtl/fetch_pc_seq_pkg.sv | 11 +
 rtl/fetch_pc_seq_if.sv | 10 +
 rtl/fetch_pc_seq_next_pc_sel.sv | 26 ++
 rtl/fetch_pc_seq.sv | 90 +++++++++
 tb/tb_fetch_pc_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_seq_pkg.sv
// Shared CPU core definitions: fetch FSM encoding and instruction/PC constants.
package cpu_pkg;
    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_pc_seq_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface fetch_pc_seq_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_pc_seq_next_pc_sel.sv
// Next-PC selection: jr > jump > branch > sequential, all modulo 2^32.
module next_pc_sel (
    input  logic [31:0] pc_plus4,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch_take,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc,
    output logic        misalign
);
    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (jr) begin
            next_pc  = jr_addr & ~32'd3;
            misalign = |jr_addr[1:0];
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_take) begin
            // offset is a word count; the shift drops its top two bits
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end
endmodule

// File: rtl/fetch_pc_seq.sv
// PC / instruction-fetch sequencer: BOOT -> FETCH <-> ISSUE with a fetch timeout.
module fetch_pc_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pc_seq_if.master        imem,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic [15:0]           imm16,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    input  logic                  stall,
    input  logic                  branch_take,
    input  logic [31:0]           branch_offset,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jr,
    input  logic [31:0]           jr_addr,
    output logic                  fetch_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_t    state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     next_pc;
    logic            misalign;

    assign pc_plus4    = pc + PC_STEP;
    assign imm16       = instr[15:0];
    assign imem.addr   = pc;
    assign imem.req    = (state == FS_FETCH);
    assign instr_valid = (state == FS_ISSUE);

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_take   (branch_take),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .misalign      (misalign)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FS_BOOT:  state_nxt = FS_FETCH;
            FS_FETCH: if (imem.ready) state_nxt = FS_ISSUE;
            FS_ISSUE: if (!stall) state_nxt = FS_FETCH;
            default:  state_nxt = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FS_BOOT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr     <= NOP_INSTR;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FS_FETCH) begin
                if (imem.ready) begin
                    instr    <= imem.rdata;
                    wait_cnt <= '0;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    // flag and keep retrying the same address
                    fetch_err <= 1'b1;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (state == FS_ISSUE && !stall) begin
                pc <= next_pc;
                if (misalign) fetch_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_seq.sv
// Scoreboarded bench for fetch_pc_seq: fetched words queued on fetch, checked on issue.
module tb_fetch_pc_seq;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, fetch_err;
    logic [15:0] imm16;
    logic        stall, branch_take, jump, jr;
    logic [31:0] branch_offset, jr_addr;
    logic [25:0] jump_index;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    fetch_pc_seq_if imem_bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hC3A5};
    endfunction

    assign imem_bus.rdata = mem_word(imem_bus.addr);

    always #5 clk = ~clk;

    fetch_pc_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .imm16         (imm16),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .branch_take   (branch_take),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .fetch_err     (fetch_err)
    );

    task automatic clear_ctrl();
        stall = 0; branch_take = 0; jump = 0; jr = 0;
        branch_offset = '0; jr_addr = '0; jump_index = '0;
    endtask

    task automatic reset_dut();
        imem_bus.ready = 0;
        clear_ctrl();
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_pc = 32'h0;
        exp_q.delete();
    endtask

    // wait (bounded) for FETCH, hand back one word, land in ISSUE
    task automatic do_fetch();
        int n = 0;
        while (!imem_bus.req && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!imem_bus.req) begin
            n_fails++;
            $display("FAIL fetch_wait: imem_req=%0b after %0d cycles, required 1", imem_bus.req, n);
        end
        imem_bus.ready = 1;
        exp_q.push_back(mem_word(exp_pc));
        @(negedge clk);
        imem_bus.ready = 0;
    endtask

    task automatic do_issue(input logic j_r, input logic [31:0] j_addr, input logic jmp,
                            input logic [25:0] idx, input logic br, input logic [31:0] off);
        jr = j_r; jr_addr = j_addr; jump = jmp; jump_index = idx;
        branch_take = br; branch_offset = off;
        @(negedge clk);
        clear_ctrl();
    endtask

    task automatic test_reset();
        imem_bus.ready = 0;
        clear_ctrl();
        rst = 1;
        #12;
        n_checks++; if (pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_checks++; if (instr !== 32'h0) begin n_fails++; $display("FAIL reset_instr: got %h want %h", instr, 32'h0); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (imem_bus.req !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b want 0", imem_bus.req); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fails++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    endtask

    task automatic test_sequential();
        logic [31:0] epc;
        reset_dut();
        imem_bus.ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            epc = 32'((k / 2) * 4);
            n_checks++; if (pc !== epc) begin n_fails++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc, epc); end
            n_checks++; if (instr_valid !== 1'(k % 2)) begin n_fails++; $display("FAIL seq_valid[%0d]: got %b want %b", k, instr_valid, 1'(k % 2)); end
            if (k % 2 == 0) begin
                exp_q.push_back(mem_word(epc));
                n_checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== epc) begin n_fails++; $display("FAIL seq_req[%0d]: req=%b addr=%h want 1 %h", k, imem_bus.req, imem_bus.addr, epc); end
            end else begin
                exp_w = exp_q.pop_front();
                n_checks++; if (instr !== exp_w || imm16 !== exp_w[15:0]) begin n_fails++; $display("FAIL seq_instr[%0d]: got %h/%h want %h", k, instr, imm16, exp_w); end
                n_checks++; if (imem_bus.req !== 1'b0) begin n_fails++; $display("FAIL seq_issue_req[%0d]: got %b want 0", k, imem_bus.req); end
            end
        end
        imem_bus.ready = 0;
    endtask

    task automatic test_branch();
        reset_dut();
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(1, 32'h10, 0, '0, 0, '0); exp_pc = 32'h10;
        do_fetch(); exp_w = exp_q.pop_front();
        n_checks++; if (instr !== exp_w) begin n_fails++; $display("FAIL br_instr: got %h want %h", instr, exp_w); end
        do_issue(0, '0, 0, '0, 1, 32'hFFFF_FFFE); exp_pc = 32'h0000_000C;
        n_checks++; if (pc !== exp_pc) begin n_fails++; $display("FAIL br_neg: got %h want %h", pc, exp_pc); end
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(1, 32'h10, 0, '0, 0, '0); exp_pc = 32'h10;
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(0, '0, 0, '0, 1, 32'h0000_0003); exp_pc = 32'h0000_0020;
        n_checks++; if (pc !== exp_pc) begin n_fails++; $display("FAIL br_pos: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_jump_priority();
        reset_dut();
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(1, 32'h4000_0008, 0, '0, 0, '0); exp_pc = 32'h4000_0008;
        do_fetch(); exp_w = exp_q.pop_front();
        n_checks++; if (instr !== exp_w) begin n_fails++; $display("FAIL jmp_instr: got %h want %h", instr, exp_w); end
        do_issue(0, '0, 1, 26'h000_0100, 1, 32'h0000_0005); exp_pc = 32'h4000_0400;
        n_checks++; if (pc !== exp_pc) begin n_fails++; $display("FAIL jmp_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("FAIL jmp_err: got %b want 0", fetch_err); end
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(1, 32'h0000_0101, 1, 26'h000_0100, 1, 32'h0000_0005); exp_pc = 32'h0000_0100;
        n_checks++; if (pc !== exp_pc) begin n_fails++; $display("FAIL jr_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (fetch_err !== 1'b1) begin n_fails++; $display("FAIL jr_misalign: got %b want 1", fetch_err); end
    endtask

    task automatic test_stall();
        reset_dut();
        do_fetch(); exp_w = exp_q.pop_front();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            branch_take = 1'(i % 2 == 0); branch_offset = 32'h40;
            @(negedge clk);
            n_checks++; if (pc !== exp_pc || instr !== exp_w || instr_valid !== 1'b1) begin
                n_fails++; $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%b want %h %h 1", i, pc, instr, instr_valid, exp_pc, exp_w);
            end
        end
        stall = 0; branch_take = 0;
        @(negedge clk);
        clear_ctrl();
        exp_pc = exp_pc + 32'd4;
        n_checks++; if (pc !== exp_pc || instr_valid !== 1'b0) begin n_fails++; $display("FAIL stall_release: pc=%h valid=%b want %h 0", pc, instr_valid, exp_pc); end
    endtask

    task automatic test_timeout();
        reset_dut();
        @(negedge clk);
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            n_checks++; if (imem_bus.req !== 1'b1 || fetch_err !== 1'(i >= TIMEOUT)) begin
                n_fails++; $display("FAIL timeout[%0d]: req=%b err=%b want 1 %b", i, imem_bus.req, fetch_err, 1'(i >= TIMEOUT));
            end
        end
        do_fetch(); exp_w = exp_q.pop_front();
        n_checks++; if (instr !== exp_w || instr_valid !== 1'b1) begin n_fails++; $display("FAIL timeout_late: instr=%h valid=%b want %h 1", instr, instr_valid, exp_w); end
        n_checks++; if (fetch_err !== 1'b1) begin n_fails++; $display("FAIL timeout_sticky: got %b want 1", fetch_err); end
    endtask

    task automatic test_reset_abort();
        reset_dut();
        do_fetch(); exp_w = exp_q.pop_front();
        do_issue(1, 32'h0000_0025, 0, '0, 0, '0); exp_pc = 32'h24;
        @(negedge clk); @(negedge clk);
        n_checks++; if (pc !== 32'h24 || fetch_err !== 1'b1 || imem_bus.req !== 1'b1) begin
            n_fails++; $display("FAIL abort_pre: pc=%h err=%b req=%b want 24 1 1", pc, fetch_err, imem_bus.req);
        end
        #2 rst = 1;
        #1;
        n_checks++; if (pc !== 32'h0 || imem_bus.req !== 1'b0 || instr !== 32'h0 || fetch_err !== 1'b0) begin
            n_fails++; $display("FAIL abort_reset: pc=%h req=%b instr=%h err=%b want 0 0 0 0", pc, imem_bus.req, instr, fetch_err);
        end
        @(negedge clk);
        rst = 0;
        exp_pc = 32'h0; exp_q.delete();
        do_fetch(); exp_w = exp_q.pop_front();
        n_checks++; if (instr !== exp_w) begin n_fails++; $display("FAIL abort_refetch: got %h want %h", instr, exp_w); end
        do_issue(1, 32'hFFFF_FFFC, 0, '0, 0, '0); exp_pc = 32'hFFFF_FFFC;
        n_checks++; if (pc !== exp_pc || pc_plus4 !== 32'h0) begin n_fails++; $display("FAIL wrap_pre: pc=%h pc_plus4=%h want fffffffc 0", pc, pc_plus4); end
        do_fetch(); exp_w = exp_q.pop_front();
        n_checks++; if (instr !== exp_w) begin n_fails++; $display("FAIL wrap_instr: got %h want %h", instr, exp_w); end
        do_issue(0, '0, 0, '0, 0, '0); exp_pc = 32'h0;
        n_checks++; if (pc !== exp_pc) begin n_fails++; $display("FAIL wrap_pc: got %h want %h", pc, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_stall();
        test_timeout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
